// File: rtl/v_uresizer_2ppc.sv
// 2x upscaler for 2-pixel-per-clock AXI4-Stream video.
// Pixels are replicated horizontally; each line is replayed from a line buffer.
module v_uresizer_2ppc #(
    parameter logic COLUMN_UP      = 1'b1,
    parameter logic LINE_UP        = 1'b1,
    parameter int   PIXEL_WIDTH    = 24,
    parameter int   S_AXIS_WIDTH   = 48,
    parameter int   M_AXIS_WIDTH   = 48,
    parameter int   MAX_LINE_BEATS = 1024,
    parameter int   ADDR_WIDTH     = 10
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [S_AXIS_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tuser,
    input  logic                    s_axis_tlast,
    output logic [M_AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tlast,
    output logic                    line_overflow
);

    localparam int PW = PIXEL_WIDTH;
    localparam logic [ADDR_WIDTH:0] MAX_B = (ADDR_WIDTH + 1)'(MAX_LINE_BEATS);

    typedef enum logic {PASS, REPLAY} state_t;

    state_t                  state_q, state_d;
    logic                    phase_q, phase_d;
    logic [ADDR_WIDTH:0]     wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH:0]     rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]     line_len_q, line_len_d;
    logic                    ovf_seen_q, ovf_seen_d;
    logic                    ovf_q, ovf_d;
    logic [M_AXIS_WIDTH-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    user_q, user_d;
    logic                    last_q, last_d;

    logic [S_AXIS_WIDTH-1:0] mem [MAX_LINE_BEATS];

    logic                    ld_ok;
    logic                    ld;
    logic [M_AXIS_WIDTH-1:0] ld_data;
    logic                    ld_user;
    logic                    ld_last;
    logic                    s_ready;
    logic                    wr_en;
    logic                    rd_last;
    logic [S_AXIS_WIDTH-1:0] src;
    logic [PW-1:0]           p0;
    logic [PW-1:0]           p1;

    assign ld_ok = m_axis_tready | ~valid_q;

    // Distributed-RAM style asynchronous read feeds the replay path.
    assign src = (state_q == REPLAY) ? mem[rd_addr_q[ADDR_WIDTH-1:0]]
                                     : s_axis_tdata;
    assign p0      = src[PW-1:0];
    assign p1      = src[2*PW-1:PW];
    assign rd_last = (rd_addr_q == line_len_q - 1'b1);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        line_len_d = line_len_q;
        ovf_seen_d = ovf_seen_q;
        ovf_d      = 1'b0;
        data_d     = data_q;
        valid_d    = ld_ok ? 1'b0 : valid_q;
        user_d     = user_q;
        last_d     = last_q;
        ld         = 1'b0;
        ld_data    = '0;
        ld_user    = 1'b0;
        ld_last    = 1'b0;
        s_ready    = 1'b0;
        wr_en      = 1'b0;

        unique case (state_q)
            PASS: begin
                if (COLUMN_UP && !phase_q) begin
                    // First half of a beat is shown without consuming it.
                    if (s_axis_tvalid && ld_ok) begin
                        ld      = 1'b1;
                        ld_data = {p0, p0};
                        ld_user = s_axis_tuser;
                        phase_d = 1'b1;
                    end
                end else begin
                    s_ready = ld_ok;
                    if (s_axis_tvalid && ld_ok) begin
                        ld      = 1'b1;
                        ld_data = COLUMN_UP ? {p1, p1} : src;
                        ld_user = COLUMN_UP ? 1'b0 : s_axis_tuser;
                        ld_last = s_axis_tlast;
                        phase_d = 1'b0;
                    end
                end

                if (s_ready && s_axis_tvalid) begin
                    if (wr_addr_q == MAX_B) begin
                        ovf_d      = ~ovf_seen_q;
                        ovf_seen_d = 1'b1;
                    end else begin
                        wr_en     = LINE_UP;
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                    if (s_axis_tlast) begin
                        line_len_d = (wr_addr_q == MAX_B) ? MAX_B
                                                          : wr_addr_q + 1'b1;
                        wr_addr_d  = '0;
                        ovf_seen_d = 1'b0;
                        state_d    = LINE_UP ? REPLAY : PASS;
                    end
                end
            end

            REPLAY: begin
                if (ld_ok) begin
                    ld = 1'b1;
                    if (COLUMN_UP && !phase_q) begin
                        ld_data = {p0, p0};
                        phase_d = 1'b1;
                    end else begin
                        ld_data = COLUMN_UP ? {p1, p1} : src;
                        ld_last = rd_last;
                        phase_d = 1'b0;
                        if (rd_last) begin
                            rd_addr_d = '0;
                            state_d   = PASS;
                        end else begin
                            rd_addr_d = rd_addr_q + 1'b1;
                        end
                    end
                end
            end

            default: state_d = PASS;
        endcase

        if (ld) begin
            data_d  = ld_data;
            valid_d = 1'b1;
            user_d  = ld_user;
            last_d  = ld_last;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= PASS;
            phase_q    <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            line_len_q <= '0;
            ovf_seen_q <= 1'b0;
            ovf_q      <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            user_q     <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            line_len_q <= line_len_d;
            ovf_seen_q <= ovf_seen_d;
            ovf_q      <= ovf_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            user_q     <= user_d;
            last_q     <= last_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr_q[ADDR_WIDTH-1:0]] <= s_axis_tdata;
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tuser  = user_q;
    assign m_axis_tlast  = last_q;
    assign line_overflow = ovf_q;

endmodule

// File: tb/tb_v_uresizer_2ppc.sv
// Scoreboard bench for v_uresizer_2ppc: default, small-buffer and
// no-column-replication instances share one stimulus bus selected by sel.
module tb_v_uresizer_2ppc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tuser = 1'b0;
    logic        s_tlast = 1'b0;
    logic        m_tready = 1'b1;
    int          sel = 0;
    int          rdy_mode = 0;

    logic [47:0] md [3];
    logic        mv [3];
    logic        mu [3];
    logic        ml [3];
    logic        sr [3];
    logic        ov [3];
    logic        sv [3];

    logic [47:0] obs_data;
    logic        obs_valid, obs_user, obs_last, obs_ready, obs_ovf;

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0;
    int first_wait = 0;
    bit mon_en = 1'b0;
    logic [49:0] exp_q [$];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 3; i++) sv[i] = s_tvalid && (sel == i);
    end

    assign obs_data  = md[sel];
    assign obs_valid = mv[sel];
    assign obs_user  = mu[sel];
    assign obs_last  = ml[sel];
    assign obs_ready = sr[sel];
    assign obs_ovf   = ov[sel];

    v_uresizer_2ppc u_def (
        .aclk(clk), .areset(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(sv[0]),
        .s_axis_tready(sr[0]), .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast), .m_axis_tdata(md[0]),
        .m_axis_tvalid(mv[0]), .m_axis_tready(m_tready),
        .m_axis_tuser(mu[0]), .m_axis_tlast(ml[0]),
        .line_overflow(ov[0])
    );

    v_uresizer_2ppc #(.MAX_LINE_BEATS(4), .ADDR_WIDTH(2)) u_small (
        .aclk(clk), .areset(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(sv[1]),
        .s_axis_tready(sr[1]), .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast), .m_axis_tdata(md[1]),
        .m_axis_tvalid(mv[1]), .m_axis_tready(m_tready),
        .m_axis_tuser(mu[1]), .m_axis_tlast(ml[1]),
        .line_overflow(ov[1])
    );

    v_uresizer_2ppc #(.COLUMN_UP(1'b0)) u_col0 (
        .aclk(clk), .areset(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(sv[2]),
        .s_axis_tready(sr[2]), .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast), .m_axis_tdata(md[2]),
        .m_axis_tvalid(mv[2]), .m_axis_tready(m_tready),
        .m_axis_tuser(mu[2]), .m_axis_tlast(ml[2]),
        .line_overflow(ov[2])
    );

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on output handshakes, checks stall hold.
    logic        pv = 1'b0;
    logic        pr = 1'b1;
    logic [49:0] pd = '0;
    logic [49:0] exp_b;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
            pr = 1'b1;
        end else if (mon_en) begin
            if (pv && !pr) begin
                checks++;
                if (!obs_valid || {obs_data, obs_user, obs_last} !== pd) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b %h exp v=1 %h",
                             obs_valid, {obs_data, obs_user, obs_last}, pd);
                end
            end
            if (obs_valid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got %h exp none",
                             {obs_data, obs_user, obs_last});
                end else begin
                    exp_b = exp_q.pop_front();
                    if ({obs_data, obs_user, obs_last} !== exp_b) begin
                        errors++;
                        $display("FAIL beat: got %h exp %h",
                                 {obs_data, obs_user, obs_last}, exp_b);
                    end
                end
            end
            if (obs_ovf) ovf_cnt++;
            pv = obs_valid;
            pr = m_tready;
            pd = {obs_data, obs_user, obs_last};
        end
    end

    task automatic send_beat(input logic [47:0] d, input bit u, input bit l,
                             output int w);
        int n;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        w = 0;
        n = 0;
        forever begin
            @(negedge clk);
            if (obs_ready) break;
            w++;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got tready=0 exp tready=1");
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_line(input int n, input bit user0);
        logic [47:0] b [$];
        logic [23:0] p0, p1;
        int nr, maxb, w;
        bit colup;
        colup = (sel != 2);
        maxb  = (sel == 1) ? 4 : 1024;
        for (int i = 0; i < n; i++)
            b.push_back({24'($urandom()), 24'($urandom())});
        for (int i = 0; i < n; i++) begin
            p0 = b[i][23:0];
            p1 = b[i][47:24];
            if (colup) begin
                exp_q.push_back({p0, p0, user0 && i == 0, 1'b0});
                exp_q.push_back({p1, p1, 1'b0, i == n - 1});
            end else begin
                exp_q.push_back({b[i], user0 && i == 0, i == n - 1});
            end
        end
        nr = (n < maxb) ? n : maxb;
        for (int i = 0; i < nr; i++) begin
            p0 = b[i][23:0];
            p1 = b[i][47:24];
            if (colup) begin
                exp_q.push_back({p0, p0, 1'b0, 1'b0});
                exp_q.push_back({p1, p1, 1'b0, i == nr - 1});
            end else begin
                exp_q.push_back({b[i], 1'b0, i == nr - 1});
            end
        end
        for (int i = 0; i < n; i++) begin
            send_beat(b[i], user0 && i == 0, i == n - 1, w);
            if (i == 0) first_wait = w;
        end
        s_tuser = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !obs_valid) break;
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats left exp 0",
                     name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if ({obs_valid, obs_data, obs_user, obs_last, obs_ovf} !== '0) begin
                errors++;
                $display("FAIL reset_out%0d: got %b %h %b %b %b exp zeros", s,
                         obs_valid, obs_data, obs_user, obs_last, obs_ovf);
            end
        end
        sel = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        sel = 0;
        rdy_mode = 0;
        send_line(3, 1'b1);
        send_line(3, 1'b1);
        checks++;
        if (first_wait != 7) begin
            errors++;
            $display("FAIL replay_block: got %0d exp 7", first_wait);
        end
        wait_drain("basic");
    endtask

    task automatic test_stall();
        sel = 0;
        rdy_mode = 1;
        send_line(3, 1'b1);
        send_line(3, 1'b1);
        wait_drain("stall");
        rdy_mode = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_one_beat();
        sel = 0;
        send_line(1, 1'b1);
        wait_drain("one_beat");
    endtask

    task automatic test_overflow();
        sel = 1;
        ovf_cnt = 0;
        send_line(6, 1'b1);
        wait_drain("overflow");
        checks++;
        if (ovf_cnt != 1) begin
            errors++;
            $display("FAIL ovf_pulses: got %0d exp 1", ovf_cnt);
        end
        sel = 0;
    endtask

    task automatic test_reset_replay();
        sel = 0;
        rdy_mode = 0;
        send_line(3, 1'b1);
        repeat (4) void'(exp_q.pop_back());
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        rdy_mode = 2;
        @(negedge clk);
        checks++;
        if (obs_valid !== 1'b1) begin
            errors++;
            $display("FAIL third_replay: got v=%b exp v=1", obs_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b exp v=0", obs_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_line(2, 1'b1);
        wait_drain("after_reset");
    endtask

    task automatic test_col0();
        sel = 2;
        send_line(3, 1'b1);
        wait_drain("col0");
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_one_beat();
        test_overflow();
        test_reset_replay();
        test_col0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/v_uresizer_2ppc.md
Name: v_uresizer_2ppc

Overview:
- 2x upscaler for 2-pixel-per-clock AXI4-Stream video. It is the counterpart of the 2:1 decimating resizer.
- Horizontal: each pixel is replicated. Vertical: each line is output twice, with the second copy replayed from an internal line buffer.
- Sits between the video source and the VDMA/output path whenever the frame must be doubled in width and/or height.

Parameters:
- COLUMN_UP, 1'b1: enable horizontal 2x pixel replication.
- LINE_UP, 1'b1: enable vertical 2x line replication.
- PIXEL_WIDTH, 24: bits per pixel.
- S_AXIS_WIDTH, 48: input tdata width; must equal 2*PIXEL_WIDTH.
- M_AXIS_WIDTH, 48: output tdata width; must equal 2*PIXEL_WIDTH.
- MAX_LINE_BEATS, 1024: line buffer depth, in input beats.
- ADDR_WIDTH, 10: line buffer address width; must be at least clog2(MAX_LINE_BEATS).

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  asynchronous reset, active-high.
- s_axis_tdata  in  S_AXIS_WIDTH  input beat {p1,p0}; p0 (first pixel) is in [PIXEL_WIDTH-1:0].
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tuser  in  1  start of frame.
- s_axis_tlast  in  1  end of line.
- m_axis_tdata  out  M_AXIS_WIDTH  output beat.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tuser  out  1  start of frame.
- m_axis_tlast  out  1  end of line.
- line_overflow  out  1  one-cycle pulse when an input line exceeds MAX_LINE_BEATS.

Behaviour:
- Reset (asynchronous, immediate): m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, line_overflow = 0. State = PASS; phase = 0; wr_addr, rd_addr, line_len = 0. Buffer contents are not reset.
- Output stage is a single register. It loads when (m_axis_tready | ~m_axis_tvalid) and a source beat is available.
- Latency: 1 cycle from an accepted or presented input beat to m_axis_tvalid.
- Output data must hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- State PASS (source is s_axis):
  - COLUMN_UP=1, phase 0: requires s_axis_tvalid. Loads {p0,p0}, m_axis_tuser=s_axis_tuser, m_axis_tlast=0. s_axis_tready=0. phase becomes 1.
  - COLUMN_UP=1, phase 1: s_axis_tready = output-load condition. On handshake, loads {p1,p1}, tuser=0, tlast=s_axis_tlast. phase becomes 0.
  - COLUMN_UP=0: loads the beat unchanged on handshake, with tuser and tlast passed through.
  - On each input handshake: if LINE_UP=1, write tdata to buf[wr_addr]. wr_addr increments and saturates at MAX_LINE_BEATS.
  - Write attempted at wr_addr==MAX_LINE_BEATS: the write is dropped and line_overflow pulses once per line.
  - On a handshake with s_axis_tlast=1: line_len = min(wr_addr+1, MAX_LINE_BEATS); wr_addr = 0. Next state is REPLAY if LINE_UP=1, otherwise PASS.
- State REPLAY (source is buf[rd_addr]; buffer read is asynchronous, distributed RAM):
  - s_axis_tready = 0 throughout.
  - Each output beat is built with the same phase/replication rules as PASS, with tuser always 0.
  - rd_addr advances after phase 1 (or on every beat if COLUMN_UP=0).
  - tlast = 1 on the final beat of entry rd_addr==line_len-1. After that beat loads: rd_addr = 0, state = PASS.
- COLUMN_UP=0 and LINE_UP=0: the block is a 1-deep register slice, and s_axis_tready = m_axis_tready | ~m_axis_tvalid.
- Output beats per input line: 2^(COLUMN_UP+LINE_UP) times the input beats (replay capped at line_len).
- An s_axis_tuser mid-line gets no special handling; it is forwarded on that beat in PASS only.
- A line with no tlast beyond buffer depth still completes its PASS copy in full; REPLAY outputs only the first MAX_LINE_BEATS input beats.
- Simultaneous output load and replay end: the state change and the load take effect on the same edge, with no bubble beat.
- areset asserted mid-line or mid-REPLAY: the partial line is discarded, and the next accepted input beat starts a fresh PASS line.

Test Plan:
- Defaults, m_axis_tready=1; 2 lines of 3 beats {B,A},{D,C},{F,E}, tuser on the first beat -> per line: AA BB CC DD EE FF(tlast) with tuser on the first AA only, then AA..FF(tlast) replay with tuser 0. 24 output beats total; s_axis_tready=0 for the 6 replay cycles.
- Same stimulus with m_axis_tready pattern 1,0,1,0 -> identical output sequence, no drop or duplicate, data and tuser/tlast stable during stalls.
- 1-beat line {B,A} with tlast -> AA, BB(tlast), AA, BB(tlast).
- MAX_LINE_BEATS=4, 6-beat line -> PASS outputs 12 beats, line_overflow pulses once, REPLAY outputs 8 beats (input beats 0-3) with tlast on the 8th.
- areset pulsed during the 3rd REPLAY beat -> m_axis_tvalid=0 immediately; after release, the next line outputs from PASS with correct tlast, and no stale replay.
- COLUMN_UP=0, LINE_UP=1, 3-beat line -> 3 beats unchanged, then the same 3 replayed, tlast on the 3rd and 6th beats.
